// File: rtl/scanline_prefetcher_if.sv
// scanline_prefetcher_if: framebuffer read bus and line buffer write bus (master = prefetcher, slave = memories)
interface scanline_prefetcher_if #(
  parameter int DATA_WIDTH = 12,
  parameter int FB_ADDRESS_WIDTH = 22,
  parameter int LINE_ADDRESS_WIDTH = 13
);
  logic [FB_ADDRESS_WIDTH-1:0] fb_read_address;
  logic [DATA_WIDTH-1:0] fb_read_data;
  logic [LINE_ADDRESS_WIDTH-1:0] line_write_address;
  logic [DATA_WIDTH-1:0] line_write_data;
  logic line_write_enable;
  modport master (
    output fb_read_address, line_write_address, line_write_data, line_write_enable,
    input fb_read_data
  );
  modport slave (
    input fb_read_address, line_write_address, line_write_data, line_write_enable,
    output fb_read_data
  );
endinterface

// File: rtl/scanline_prefetcher.sv
// scanline_prefetcher: copies framebuffer lines into a double-banded line buffer ahead of the VGA side; underrun_count present only with SCANLINE_PREFETCHER_UNDERRUN_COUNT_EN
module scanline_prefetcher #(
  parameter int DATA_WIDTH = 12,
  parameter int FB_ADDRESS_WIDTH = 22,
  parameter int LINE_PIXELS = 640,
  parameter int LINE_ADDRESS_WIDTH = 13,
  parameter int LINE_REPEAT = 2
) (
  input logic system_clock,
  input logic reset_n,
  input logic enable,
  input logic frame_start,
  input logic [FB_ADDRESS_WIDTH-1:0] frame_base,
  input logic line_finished,
  scanline_prefetcher_if.master bus,
  output logic display_bank,
  output logic busy,
  output logic underrun,
  output logic [7:0] underrun_count
);
  localparam int OW = LINE_ADDRESS_WIDTH - 1;
  localparam logic [OW-1:0] LAST = OW'(LINE_PIXELS - 1);
  localparam logic [3:0] REP_LAST = 4'(LINE_REPEAT - 1);
  typedef enum logic [1:0] {IDLE, PRIME, COPY, WAIT_LINE} state_t;
  state_t state_q, state_d;
  logic [2:0] sync_q, sync_d;
  logic [FB_ADDRESS_WIDTH-1:0] line_start_q, line_start_d;
  logic [OW-1:0] offset_q, offset_d;
  logic [3:0] repeat_q, repeat_d;
  logic display_bank_q, display_bank_d, underrun_q, underrun_d;
  logic line_end, copying, swap;
  always_comb begin
    sync_d = {sync_q[1:0], line_finished};
    line_end = sync_q[1] & ~sync_q[2];
    copying = state_q == PRIME || state_q == COPY;
    swap = enable && !frame_start && state_q != IDLE && line_end && repeat_q == REP_LAST;
    state_d = state_q;
    line_start_d = line_start_q;
    offset_d = offset_q;
    repeat_d = repeat_q;
    display_bank_d = display_bank_q;
    underrun_d = underrun_q;
    if (!enable) begin
      state_d = IDLE;
    end else if (frame_start) begin
      state_d = PRIME;
      line_start_d = frame_base;
      offset_d = '0;
      repeat_d = '0;
      underrun_d = 1'b0;
    end else if (swap) begin
      state_d = PRIME;
      line_start_d = line_start_q + FB_ADDRESS_WIDTH'(LINE_PIXELS);
      offset_d = '0;
      repeat_d = '0;
      display_bank_d = !display_bank_q;
      underrun_d = underrun_q | copying;
    end else if (state_q != IDLE) begin
      repeat_d = repeat_q + 4'(line_end);
      state_d = state_q == PRIME ? COPY : state_q == COPY && offset_q == LAST ? WAIT_LINE : state_q;
      offset_d = state_q != COPY ? offset_q : offset_q == LAST ? '0 : offset_q + OW'(1);
    end
  end
  always_ff @(posedge system_clock) begin
    state_q <= reset_n ? state_d : IDLE;
    sync_q <= reset_n ? sync_d : '0;
    line_start_q <= reset_n ? line_start_d : '0;
    offset_q <= reset_n ? offset_d : '0;
    repeat_q <= reset_n ? repeat_d : '0;
    display_bank_q <= reset_n ? display_bank_d : 1'b0;
    underrun_q <= reset_n ? underrun_d : 1'b0;
  end
  assign bus.fb_read_address = state_q == PRIME ? line_start_q :
                               state_q == COPY ? line_start_q + FB_ADDRESS_WIDTH'(offset_q) + FB_ADDRESS_WIDTH'(1) : '0;
  assign bus.line_write_enable = state_q == COPY;
  assign bus.line_write_address = state_q == COPY ? {!display_bank_q, offset_q} : '0;
  assign bus.line_write_data = state_q == COPY ? bus.fb_read_data : DATA_WIDTH'(0);
  assign busy = copying;
  assign display_bank = display_bank_q;
  assign underrun = underrun_q;
`ifdef SCANLINE_PREFETCHER_UNDERRUN_COUNT_EN
  logic [7:0] count_q, count_d;
  always_comb count_d = enable && frame_start ? 8'd0 : swap && copying && count_q != 8'hff ? count_q + 8'd1 : count_q;
  always_ff @(posedge system_clock) count_q <= reset_n ? count_d : 8'd0;
  assign underrun_count = count_q;
`else
  assign underrun_count = 8'd0;
`endif
endmodule

// File: tb/tb_scanline_prefetcher.sv
// tb_scanline_prefetcher: randomized scoreboard bench for scanline_prefetcher
module tb_scanline_prefetcher;
  localparam int DW = 12, FAW = 22, LAW = 13, LP = 640;
`ifdef SCANLINE_PREFETCHER_UNDERRUN_COUNT_EN
  localparam logic [7:0] EXP_CNT = 8'd1;
`else
  localparam logic [7:0] EXP_CNT = 8'd0;
`endif
  logic system_clock = 1'b0, reset_n = 1'b0, enable = 1'b0, frame_start = 1'b0, line_finished = 1'b0;
  logic [FAW-1:0] frame_base = '0;
  logic display_bank, busy, underrun;
  logic [7:0] underrun_count;
  int cyc = 0, n_chk = 0, n_fail = 0;
  logic [DW-1:0] salt = '0;
  typedef struct packed {logic [LAW-1:0] a; logic [DW-1:0] d;} wr_t;
  wr_t exp_q[$];
  wr_t mon_w;
  scanline_prefetcher_if #(.DATA_WIDTH(DW), .FB_ADDRESS_WIDTH(FAW), .LINE_ADDRESS_WIDTH(LAW)) bus();
  scanline_prefetcher dut (
    .system_clock(system_clock), .reset_n(reset_n), .enable(enable), .frame_start(frame_start),
    .frame_base(frame_base), .line_finished(line_finished), .bus(bus), .display_bank(display_bank),
    .busy(busy), .underrun(underrun), .underrun_count(underrun_count)
  );
  always #5 system_clock = ~system_clock;
  always @(posedge system_clock) cyc <= cyc + 1;
  function automatic logic [DW-1:0] fbv(input logic [FAW-1:0] a);
    return a[11:0] ^ a[21:10] ^ salt;
  endfunction
  always @(posedge system_clock) bus.fb_read_data <= fbv(bus.fb_read_address);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge system_clock);
      #1;
    end
  endtask
  task automatic push_copy(input logic [FAW-1:0] base, input logic bank, input int n);
    wr_t w;
    for (int o = 0; o < n; o++) begin
      w.a = {bank, 12'(o)};
      w.d = fbv(base + FAW'(o));
      exp_q.push_back(w);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_we"}, 32'(bus.line_write_enable), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_bank"}, 32'(display_bank), 0);
    chk({tag, "_underrun"}, 32'(underrun), 0);
    chk({tag, "_count"}, 32'(underrun_count), 0);
    chk({tag, "_fb_addr"}, 32'(bus.fb_read_address), 0);
    chk({tag, "_lw_addr"}, 32'(bus.line_write_address), 0);
    chk({tag, "_lw_data"}, 32'(bus.line_write_data), 0);
  endtask
  always @(negedge system_clock)
    if (bus.line_write_enable === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_write", 32'(bus.line_write_address), 32'hffffffff);
      else begin
        mon_w = exp_q.pop_front();
        chk("wr_addr", 32'(bus.line_write_address), 32'(mon_w.a));
        chk("wr_data", 32'(bus.line_write_data), 32'(mon_w.d));
      end
    end
  always @(posedge system_clock)
    if (cyc > 20000) begin
      $display("FAIL watchdog: cycle %0d exceeded budget 20000", cyc);
      $fatal(1);
    end
  initial begin
    int p, r, rd, p3, re, rf, p4, k, g1, g2, g3, p5, rg, p6, k2, j, rh;
    logic [FAW-1:0] x, y;
    salt = 12'($urandom);
    wait_until(3);
    chk_zero("reset");
    reset_n = 1'b1;
    enable = 1'b1;
    wait_until(6);
    chk("idle_busy", 32'(busy), 0);
    frame_base = 22'h100;
    push_copy(22'h100, 1'b1, LP);
    frame_start = 1'b1;
    wait_until(7);
    p = 7;
    frame_start = 1'b0;
    chk("prime_busy", 32'(busy), 1);
    chk("prime_fb_addr", 32'(bus.fb_read_address), 32'h100);
    chk("prime_we", 32'(bus.line_write_enable), 0);
    wait_until(p + 1);
    chk("copy0_fb_addr", 32'(bus.fb_read_address), 32'h101);
    wait_until(p + LP);
    chk("last_copy_busy", 32'(busy), 1);
    wait_until(p + LP + 1);
    chk("copy_done_busy", 32'(busy), 0);
    chk("copy_done_bank", 32'(display_bank), 0);
    r = cyc + 5;
    wait_until(r);
    line_finished = 1'b1;
    wait_until(r + 4);
    line_finished = 1'b0;
    wait_until(r + 10);
    chk("first_end_bank", 32'(display_bank), 0);
    chk("first_end_busy", 32'(busy), 0);
    r = cyc + 3;
    push_copy(22'h380, 1'b0, LP);
    wait_until(r);
    line_finished = 1'b1;
    wait_until(r + 3);
    p = r + 3;
    chk("swap_bank", 32'(display_bank), 1);
    chk("swap_busy", 32'(busy), 1);
    chk("swap_fb_addr", 32'(bus.fb_read_address), 32'h380);
    wait_until(r + 4);
    line_finished = 1'b0;
    wait_until(p + LP + 1);
    chk("copy2_done_busy", 32'(busy), 0);
    chk("copy2_underrun", 32'(underrun), 0);
    r = cyc + 5;
    wait_until(r);
    line_finished = 1'b1;
    wait_until(r + 4);
    line_finished = 1'b0;
    wait_until(r + 10);
    chk("repeat_bank", 32'(display_bank), 1);
    g1 = $urandom_range(60, 8);
    g2 = $urandom_range(150, 10);
    rd = cyc + 3;
    p3 = rd + 3;
    re = p3 + g1;
    rf = re + g2;
    p4 = rf + 3;
    k = p4 - 1 - p3;
    push_copy(22'h600, 1'b1, k);
    push_copy(22'h880, 1'b0, 101);
    wait_until(rd);
    line_finished = 1'b1;
    wait_until(p3);
    chk("copy3_bank", 32'(display_bank), 0);
    chk("copy3_fb_addr", 32'(bus.fb_read_address), 32'h600);
    chk("copy3_underrun", 32'(underrun), 0);
    wait_until(rd + 4);
    line_finished = 1'b0;
    wait_until(re);
    line_finished = 1'b1;
    wait_until(re + 4);
    line_finished = 1'b0;
    wait_until(re + 8);
    chk("mid_repeat_busy", 32'(busy), 1);
    chk("mid_repeat_underrun", 32'(underrun), 0);
    wait_until(rf);
    line_finished = 1'b1;
    wait_until(p4);
    chk("underrun_flag", 32'(underrun), 1);
    chk("underrun_count", 32'(underrun_count), 32'(EXP_CNT));
    chk("underrun_bank", 32'(display_bank), 1);
    chk("underrun_fb_addr", 32'(bus.fb_read_address), 32'h880);
    chk("underrun_busy", 32'(busy), 1);
    wait_until(rf + 4);
    line_finished = 1'b0;
    wait_until(p4 + 101);
    enable = 1'b0;
    chk("dis_last_we", 32'(bus.line_write_enable), 1);
    wait_until(p4 + 102);
    chk("dis_we", 32'(bus.line_write_enable), 0);
    chk("dis_busy", 32'(busy), 0);
    chk("dis_underrun", 32'(underrun), 1);
    r = cyc + 3;
    wait_until(r);
    line_finished = 1'b1;
    wait_until(r + 4);
    line_finished = 1'b0;
    wait_until(r + 12);
    chk("dis_ignore_bank", 32'(display_bank), 1);
    chk("dis_ignore_busy", 32'(busy), 0);
    enable = 1'b1;
    wait_until(cyc + 2);
    x = FAW'($urandom);
    y = 22'h3fff80 + FAW'($urandom_range(63, 0));
    g3 = $urandom_range(200, 20);
    j = $urandom_range(400, 300);
    p5 = cyc + 1;
    rg = p5 + g3;
    p6 = rg + 3;
    k2 = p6 - 1 - p5;
    push_copy(x, 1'b0, k2);
    push_copy(y, 1'b0, j + 1);
    frame_base = x;
    frame_start = 1'b1;
    wait_until(p5);
    frame_start = 1'b0;
    chk("fs_underrun_clr", 32'(underrun), 0);
    chk("fs_count_clr", 32'(underrun_count), 0);
    chk("fs_bank", 32'(display_bank), 1);
    chk("fs_fb_addr", 32'(bus.fb_read_address), 32'(x));
    wait_until(rg);
    line_finished = 1'b1;
    wait_until(rg + 2);
    frame_base = y;
    frame_start = 1'b1;
    wait_until(p6);
    frame_start = 1'b0;
    chk("coinc_bank", 32'(display_bank), 1);
    chk("coinc_underrun", 32'(underrun), 0);
    chk("coinc_fb_addr", 32'(bus.fb_read_address), 32'(y));
    chk("coinc_busy", 32'(busy), 1);
    wait_until(rg + 4);
    line_finished = 1'b0;
    rh = p6 + 20;
    wait_until(rh);
    line_finished = 1'b1;
    wait_until(rh + 4);
    line_finished = 1'b0;
    wait_until(rh + 8);
    chk("post_coinc_bank", 32'(display_bank), 1);
    chk("post_coinc_busy", 32'(busy), 1);
    wait_until(p6 + 1 + j);
    reset_n = 1'b0;
    chk("pre_reset_we", 32'(bus.line_write_enable), 1);
    wait_until(p6 + 2 + j);
    chk_zero("midreset");
    reset_n = 1'b1;
    wait_until(cyc + 5);
    chk("queue_drained", 32'(exp_q.size()), 0);
    chk("final_busy", 32'(busy), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
